// File: rtl/obstacle_gen.sv
// Obstacle generator: scrolls up to NSLOT obstacles left on each game tick,
// retires the ones that leave the screen and spawns new ones at the right
// edge after a pseudo-random gap that is never below min_empty.
module obstacle_gen #(
  parameter int NSLOT   = 4,
  parameter int XW      = 10,
  parameter int STEP    = 4,
  parameter int SPAWN_X = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_clk,
  input  logic [8:0]            min_empty,
  input  logic                  start,
  input  logic                  crash,
  output logic [1:0]            state,
  output logic [NSLOT-1:0]      obs_valid,
  output logic [NSLOT*XW-1:0]   obs_x,
  output logic [2*NSLOT-1:0]    obs_type,
  output logic                  spawn
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [XW-1:0] STEP_X  = XW'(STEP);
  localparam logic [XW-1:0] SPAWN_V = XW'(SPAWN_X);
  localparam logic [9:0]    STEP_G  = 10'(STEP);
  localparam logic [9:0]    GAP_MAX = 10'd1023;

  state_t               cur_state;
  state_t               nxt_state;
  logic                 game_clk_d;
  logic                 tick;
  logic [15:0]          lfsr;
  logic [9:0]           gap_cnt;
  logic [9:0]           next_gap;

  logic [NSLOT-1:0]     valid_n;
  logic [NSLOT*XW-1:0]  x_n;
  logic [2*NSLOT-1:0]   type_n;
  logic [9:0]           gap_n;
  logic [9:0]           next_gap_n;
  logic                 spawn_n;
  logic                 free_found;
  logic [NSLOT-1:0]     spawn_sel;

  assign tick  = game_clk & ~game_clk_d;
  assign state = cur_state;

  // Next-state and next slot contents; the free slot is chosen from the
  // pre-edge valid flags so a slot retiring on this tick is not reused yet.
  always_comb begin
    nxt_state  = cur_state;
    valid_n    = obs_valid;
    x_n        = obs_x;
    type_n     = obs_type;
    gap_n      = gap_cnt;
    next_gap_n = next_gap;
    spawn_n    = 1'b0;
    free_found = 1'b0;
    spawn_sel  = '0;

    for (int i = 0; i < NSLOT; i++) begin
      if (!obs_valid[i] && !free_found) begin
        free_found   = 1'b1;
        spawn_sel[i] = 1'b1;
      end
    end

    case (cur_state)
      IDLE, HALT: begin
        if (start) begin
          nxt_state  = RUN;
          valid_n    = '0;
          gap_n      = '0;
          next_gap_n = {1'b0, min_empty};
        end
      end
      RUN: begin
        if (crash) begin
          nxt_state = HALT;
        end else if (tick) begin
          for (int i = 0; i < NSLOT; i++) begin
            if (obs_valid[i]) begin
              if (obs_x[i*XW +: XW] >= STEP_X) begin
                x_n[i*XW +: XW] = obs_x[i*XW +: XW] - STEP_X;
              end else begin
                valid_n[i] = 1'b0;
              end
            end
          end
          if ((gap_cnt >= next_gap) && free_found) begin
            for (int i = 0; i < NSLOT; i++) begin
              if (spawn_sel[i]) begin
                valid_n[i]        = 1'b1;
                x_n[i*XW +: XW]   = SPAWN_V;
                type_n[2*i +: 2]  = lfsr[7:6];
              end
            end
            gap_n      = '0;
            next_gap_n = {1'b0, min_empty} + {4'b0, lfsr[5:0]};
            spawn_n    = 1'b1;
          end else if (gap_cnt > GAP_MAX - STEP_G) begin
            gap_n = GAP_MAX;
          end else begin
            gap_n = gap_cnt + STEP_G;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State, slot, gap and LFSR registers; the LFSR free-runs in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state  <= IDLE;
      obs_valid  <= '0;
      obs_x      <= '0;
      obs_type   <= '0;
      spawn      <= 1'b0;
      gap_cnt    <= '0;
      next_gap   <= '0;
      game_clk_d <= 1'b0;
      lfsr       <= 16'hACE1;
    end else begin
      cur_state  <= nxt_state;
      obs_valid  <= valid_n;
      obs_x      <= x_n;
      obs_type   <= type_n;
      spawn      <= spawn_n;
      gap_cnt    <= gap_n;
      next_gap   <= next_gap_n;
      game_clk_d <= game_clk;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed testbench for obstacle_gen: spawn timing, scrolling, retirement,
// full-slot blocking, crash freeze/restart, tick edge detection and reset.
module tb_obstacle_gen;

  localparam int NSLOT = 4;
  localparam int XW    = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                game_clk;
  logic [8:0]          min_empty;
  logic                start;
  logic                crash;
  logic [1:0]          state;
  logic [NSLOT-1:0]    obs_valid;
  logic [NSLOT*XW-1:0] obs_x;
  logic [2*NSLOT-1:0]  obs_type;
  logic                spawn;

  int          tests = 0;
  int          failures = 0;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_prev;
  logic        spawn_seen;
  logic [15:0] tick_lfsr;
  int          n;
  int          n_exp;
  int          cnt;
  int          g1;

  obstacle_gen #(.NSLOT(NSLOT), .XW(XW), .STEP(4), .SPAWN_X(640)) dut (
    .clk(clk), .rst(rst), .game_clk(game_clk), .min_empty(min_empty),
    .start(start), .crash(crash), .state(state), .obs_valid(obs_valid),
    .obs_x(obs_x), .obs_type(obs_type), .spawn(spawn)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR; lfsr_prev holds the value the design saw at the last edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsr_step(lfsr_m);
    end
  end

  function automatic logic [XW-1:0] slot_x(input int i);
    return obs_x[i*XW +: XW];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c);
    start = s;
    crash = c;
    @(negedge clk);
    start = 1'b0;
    crash = 1'b0;
  endtask

  task automatic do_tick();
    game_clk = 1'b1;
    @(negedge clk);
    spawn_seen = spawn;
    tick_lfsr  = lfsr_prev;
    game_clk   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; game_clk = 1'b0; start = 1'b0; crash = 1'b0; min_empty = 9'd240;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_valid", obs_valid, 0);
    checkOutput("reset_x", obs_x[31:0], 0);
    checkOutput("reset_type", obs_type, 0);
    checkOutput("reset_spawn", spawn, 0);
    rst = 1'b1;

    // No start: nothing spawns while idle.
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      do_tick();
      if (spawn_seen) cnt++;
    end
    checkOutput("idle_spawns", cnt, 0);
    checkOutput("idle_valid", obs_valid, 0);
    checkOutput("idle_state", state, 0);

    // First spawn after 60 ticks of gap accumulation.
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_state", state, 1);
    checkOutput("start_valid", obs_valid, 0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      do_tick();
      if (spawn_seen) cnt++;
    end
    checkOutput("pre_spawn_count", cnt, 0);
    checkOutput("pre_spawn_valid", obs_valid, 0);
    do_tick();
    checkOutput("tick61_spawn", spawn_seen, 1);
    checkOutput("tick61_valid", obs_valid, 4'b0001);
    checkOutput("tick61_x0", slot_x(0), 640);
    checkOutput("tick61_type0", obs_type[1:0], tick_lfsr[7:6]);
    g1 = 240 + int'(tick_lfsr[5:0]);
    min_empty = 9'd100;
    do_tick();
    checkOutput("tick62_x0", slot_x(0), 636);

    // Second spawn: pending gap uses min_empty sampled at the previous spawn.
    n = 1;
    n_exp = (g1 + 3) / 4 + 1;
    spawn_seen = 1'b0;
    while (n < 100 && !spawn_seen) begin
      do_tick();
      n++;
    end
    checkOutput("second_spawn_delay", n, n_exp);
    checkOutput("second_spawn_valid", obs_valid, 4'b0011);
    checkOutput("second_spawn_x1", slot_x(1), 640);
    checkOutput("second_spawn_x0", slot_x(0), 640 - 4 * n);
    checkOutput("second_spawn_type1", obs_type[3:2], tick_lfsr[7:6]);

    // Retire boundary for slot 0.
    for (int k = n; k < 159; k++) do_tick();
    checkOutput("x4_x0", slot_x(0), 4);
    do_tick();
    checkOutput("x0_x0", slot_x(0), 0);
    checkOutput("x0_valid0", obs_valid[0], 1);
    do_tick();
    checkOutput("retired_valid0", obs_valid[0], 0);
    checkOutput("retired_x0", slot_x(0), 0);

    // Start while running is ignored; crash halts; start restarts with min_empty=0.
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_in_run_state", state, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("crash_state", state, 2);
    min_empty = 9'd0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_state", state, 1);
    checkOutput("restart_valid", obs_valid, 0);

    // Full slots: slot 0 spawns on tick 1, retires on tick 162, refilled on 163.
    do_tick();
    checkOutput("full_tick1_spawn", spawn_seen, 1);
    checkOutput("full_tick1_x0", slot_x(0), 640);
    for (int k = 2; k <= 100; k++) do_tick();
    checkOutput("full_valid", obs_valid, 4'b1111);
    cnt = 0;
    for (int k = 101; k <= 162; k++) begin
      do_tick();
      if (spawn_seen) cnt++;
    end
    checkOutput("full_no_spawn", cnt, 0);
    checkOutput("full_retired_valid0", obs_valid[0], 0);
    do_tick();
    checkOutput("refill_spawn", spawn_seen, 1);
    checkOutput("refill_valid0", obs_valid[0], 1);
    checkOutput("refill_x0", slot_x(0), 640);

    // Crash coincident with a tick: no scroll, scene frozen.
    crash = 1'b1;
    game_clk = 1'b1;
    @(negedge clk);
    checkOutput("crash_tick_state", state, 2);
    checkOutput("crash_tick_x0", slot_x(0), 640);
    checkOutput("crash_tick_spawn", spawn, 0);
    crash = 1'b0;
    game_clk = 1'b0;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      do_tick();
      if (spawn_seen) cnt++;
    end
    checkOutput("halt_spawns", cnt, 0);
    checkOutput("halt_x0", slot_x(0), 640);
    checkOutput("halt_valid0", obs_valid[0], 1);
    checkOutput("halt_state", state, 2);

    // Restart with min_empty=8: gap_cnt restarts at 0, so spawn on tick 3.
    min_empty = 9'd8;
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart2_state", state, 1);
    checkOutput("restart2_valid", obs_valid, 0);
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      do_tick();
      if (spawn_seen) cnt++;
    end
    checkOutput("restart2_early_spawns", cnt, 0);
    do_tick();
    checkOutput("restart2_tick3_spawn", spawn_seen, 1);
    checkOutput("restart2_tick3_x0", slot_x(0), 640);

    // Edge detection: a long high level scrolls once; a long low level never.
    game_clk = 1'b1;
    repeat (50) @(negedge clk);
    game_clk = 1'b0;
    @(negedge clk);
    checkOutput("long_high_x0", slot_x(0), 636);
    repeat (50) @(negedge clk);
    checkOutput("long_low_x0", slot_x(0), 636);

    // Asynchronous reset mid-run clears outputs immediately.
    rst = 1'b0;
    #1;
    checkOutput("async_reset_state", state, 0);
    checkOutput("async_reset_valid", obs_valid, 0);
    checkOutput("async_reset_x", obs_x[31:0], 0);
    checkOutput("async_reset_type", obs_type, 0);
    checkOutput("async_reset_spawn", spawn, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      do_tick();
      if (spawn_seen) cnt++;
    end
    checkOutput("post_reset_spawns", cnt, 0);
    checkOutput("post_reset_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
